// File: rtl/hack_pkg.sv
// hack_pkg: shared widths and FSM state encoding for the Hack divider coprocessor.
package hack_pkg;
  localparam int DIV_WIDTH = 16;
  localparam int DIV_CNT_W = 4;
  typedef enum logic [2:0] {IDLE, RUN, ZERO, FIX, DONE} state_t;
endpackage

// File: rtl/div_sub_stage.sv
// div_sub_stage: one restoring-division trial subtract.
//   a      in  WIDTH+1  shifted partial remainder
//   b      in  WIDTH    divisor
//   diff   out WIDTH    a - b (meaningful when borrow=0)
//   borrow out 1        a < b; the partial remainder is always below 2*b,
//                       so the top bit of the (WIDTH+1)-bit difference is the borrow
module div_sub_stage #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  assign {borrow, diff} = a - {1'b0, b};
endmodule

// File: rtl/div16_seq.sv
// div16_seq: multi-cycle restoring shift-subtract divider, one quotient bit per clock.
//   clk, rst_n (async active-low), start/ready/busy/done handshake,
//   dividend/divisor sampled when start is accepted, quotient/remainder/div_by_zero
//   held from done until the next accepted start.
//   Build option DIV16_SIGNED_EN: adds signed_op and a FIX state applying result signs.
module div16_seq
  import hack_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV16_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  state_t state;
  logic [WIDTH-1:0] a, r, d, diff, r_nxt, a_nxt, dd_mag, dv_mag;
  logic [DIV_CNT_W-1:0] cnt;
  logic borrow;
`ifdef DIV16_SIGNED_EN
  logic sq, sr, dd_neg, dv_neg;
  assign dd_neg = signed_op & dividend[WIDTH-1];
  assign dv_neg = signed_op & divisor[WIDTH-1];
  assign dd_mag = dd_neg ? -dividend : dividend;
  assign dv_mag = dv_neg ? -divisor : divisor;
`else
  assign dd_mag = dividend;
  assign dv_mag = divisor;
`endif

  div_sub_stage #(.WIDTH(WIDTH)) u_sub (
    .a      ({r, a[WIDTH-1]}),
    .b      (d),
    .diff   (diff),
    .borrow (borrow)
  );

  // a shifts the dividend out at the top and the quotient bits in at the bottom
  assign r_nxt = borrow ? {r[WIDTH-2:0], a[WIDTH-1]} : diff;
  assign a_nxt = {a[WIDTH-2:0], ~borrow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ready       <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      a           <= '0;
      r           <= '0;
      d           <= '0;
      cnt         <= '0;
`ifdef DIV16_SIGNED_EN
      sq          <= 1'b0;
      sr          <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          ready       <= 1'b0;
          busy        <= 1'b1;
          quotient    <= '0;
          remainder   <= '0;
          div_by_zero <= 1'b0;
          r           <= '0;
          cnt         <= '0;
          d           <= dv_mag;
          // zero path keeps the raw dividend so it can be returned as the remainder
          a           <= (divisor == '0) ? dividend : dd_mag;
          state       <= (divisor == '0) ? ZERO : RUN;
`ifdef DIV16_SIGNED_EN
          sq          <= (divisor != '0) & (dd_neg ^ dv_neg);
          sr          <= (divisor != '0) & dd_neg;
`endif
        end
        RUN: begin
          a   <= a_nxt;
          r   <= r_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == DIV_CNT_W'(WIDTH - 1)) begin
`ifdef DIV16_SIGNED_EN
            state <= FIX;
`else
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= a_nxt;
            remainder <= r_nxt;
`endif
          end
        end
        ZERO: begin
`ifdef DIV16_SIGNED_EN
          a     <= '1;
          r     <= a;
          state <= FIX;
`else
          quotient    <= '1;
          remainder   <= a;
          div_by_zero <= 1'b1;
          busy        <= 1'b0;
          done        <= 1'b1;
          state       <= DONE;
`endif
        end
`ifdef DIV16_SIGNED_EN
        FIX: begin
          quotient    <= sq ? -a : a;
          remainder   <= sr ? -r : r;
          div_by_zero <= (d == '0);
          busy        <= 1'b0;
          done        <= 1'b1;
          state       <= DONE;
        end
`endif
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
